mult_arbiter: RTL

Arbiter and sequencer that shares one sequential signed multiplier (the 9-bit two's-complement shift-add datapath and its control unit) between two requesters. It samples requests, grants one requester in round-robin order and latches its operands. It then pulses the multiplier start, waits for the multiplier done flag (bounded by a timeout), and returns the tagged product on a shared result port.

---
 rtl/mult_arbiter.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Round-robin front end sharing one sequential signed multiplier between two
// requesters; returns each product tagged with its requester, or a timeout error.
module mult_arbiter #(
   parameter int WIDTH     = 9,
   parameter int RES_WIDTH = 17,
   parameter int TIMEOUT   = 40
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 req0,
   input  logic [WIDTH-1:0]     a0,
   input  logic [WIDTH-1:0]     b0,
   output logic                 gnt0,
   input  logic                 req1,
   input  logic [WIDTH-1:0]     a1,
   input  logic [WIDTH-1:0]     b1,
   output logic                 gnt1,
   output logic                 mul_start,
   output logic [WIDTH-1:0]     mul_a,
   output logic [WIDTH-1:0]     mul_b,
   input  logic                 mul_done,
   input  logic [RES_WIDTH-1:0] mul_res,
   output logic [RES_WIDTH-1:0] res_out,
   output logic                 res_valid,
   output logic                 res_id,
   output logic                 res_err,
   output logic                 busy
);

   localparam int TW = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMER_MAX  = TW'(TIMEOUT);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t                 state_q, state_d;
   logic [TW-1:0]          timer_q, timer_d;
   logic                   last_q, last_d;
   logic                   id_q, id_d;
   logic                   gnt0_q, gnt0_d;
   logic                   gnt1_q, gnt1_d;
   logic                   start_q, start_d;
   logic [WIDTH-1:0]       mulA_q, mulA_d;
   logic [WIDTH-1:0]       mulB_q, mulB_d;
   logic [RES_WIDTH-1:0]   resOut_q, resOut_d;
   logic                   resValid_q, resValid_d;
   logic                   resId_q, resId_d;
   logic                   resErr_q, resErr_d;
   logic                   busy_q, busy_d;
   logic                   winner;

   // last resets to 1 so requester 0 wins the first tie.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         last_q     <= 1'b1;
         id_q       <= 1'b0;
         gnt0_q     <= 1'b0;
         gnt1_q     <= 1'b0;
         start_q    <= 1'b0;
         mulA_q     <= '0;
         mulB_q     <= '0;
         resOut_q   <= '0;
         resValid_q <= 1'b0;
         resId_q    <= 1'b0;
         resErr_q   <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         last_q     <= last_d;
         id_q       <= id_d;
         gnt0_q     <= gnt0_d;
         gnt1_q     <= gnt1_d;
         start_q    <= start_d;
         mulA_q     <= mulA_d;
         mulB_q     <= mulB_d;
         resOut_q   <= resOut_d;
         resValid_q <= resValid_d;
         resId_q    <= resId_d;
         resErr_q   <= resErr_d;
         busy_q     <= busy_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      last_d     = last_q;
      id_d       = id_q;
      gnt0_d     = 1'b0;
      gnt1_d     = 1'b0;
      start_d    = 1'b0;
      mulA_d     = mulA_q;
      mulB_d     = mulB_q;
      resOut_d   = resOut_q;
      resValid_d = 1'b0;
      resId_d    = resId_q;
      resErr_d   = resErr_q;
      winner     = 1'b0;

      case (state_q)
         IDLE: begin
            if (req0 | req1) begin
               winner  = (req0 & req1) ? ~last_q : req1;
               mulA_d  = winner ? a1 : a0;
               mulB_d  = winner ? b1 : b0;
               id_d    = winner;
               gnt0_d  = ~winner;
               gnt1_d  = winner;
               start_d = 1'b1;
               timer_d = '0;
               state_d = WAIT;
            end
         end

         // The timeout fires at the end of the TIMEOUT-th WAIT cycle; done wins a tie.
         WAIT: begin
            timer_d = (timer_q == TIMER_MAX) ? timer_q : timer_q + TW'(1);
            if (mul_done) begin
               resOut_d   = mul_res;
               resErr_d   = 1'b0;
               resValid_d = 1'b1;
               resId_d    = id_q;
               state_d    = RESP;
            end else if (timer_q >= TIMER_LAST) begin
               resOut_d   = '0;
               resErr_d   = 1'b1;
               resValid_d = 1'b1;
               resId_d    = id_q;
               state_d    = RESP;
            end
         end

         RESP: begin
            last_d  = id_q;
            state_d = IDLE;
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      busy_d = (state_d != IDLE);
   end

   assign gnt0      = gnt0_q;
   assign gnt1      = gnt1_q;
   assign mul_start = start_q;
   assign mul_a     = mulA_q;
   assign mul_b     = mulB_q;
   assign res_out   = resOut_q;
   assign res_valid = resValid_q;
   assign res_id    = resId_q;
   assign res_err   = resErr_q;
   assign busy      = busy_q;

endmodule
